// File: rtl/acam_fifo_readout_ctrl_pkg.sv
// Shared types and constants for the TDC-GPX I-mode FIFO readout controller.
package acam_readout_pkg;

  localparam int unsigned C_WORD_W  = 28;
  localparam int unsigned C_FINE_W  = 17;
  localparam int unsigned C_START_W = 8;
  localparam int unsigned C_CHAN_W  = 3;

  localparam logic [3:0] C_ADR_IFIFO0 = 4'h8;
  localparam logic [3:0] C_ADR_IFIFO1 = 4'h9;

  typedef logic [C_WORD_W-1:0] acam_word_t;

  typedef struct packed {
    logic [C_FINE_W-1:0]  fine;
    logic                 slope;
    logic [C_START_W-1:0] start_nb;
    logic [C_CHAN_W-1:0]  channel;
  } acam_ts_t;

  typedef enum logic [1:0] {IDLE, SETUP, RD_LOW, RELEASE} state_t;

  // Split a raw I-mode word; the FIFO index becomes the channel MSB.
  function automatic acam_ts_t decode_word(input logic fifo_id, input acam_word_t w);
    acam_ts_t ts;
    ts.fine     = w[16:0];
    ts.slope    = w[17];
    ts.start_nb = w[25:18];
    ts.channel  = {fifo_id, w[27:26]};
    return ts;
  endfunction

endpackage

// File: rtl/acam_fifo_readout_ctrl_if.sv
// GPX parallel bus plus the timestamp valid/ready output of the readout controller.
interface acam_fifo_readout_ctrl_if;
  import acam_readout_pkg::*;

  logic       acam_csn_o;
  logic       acam_rdn_o;
  logic       acam_wrn_o;
  logic [3:0] acam_adr_o;
  acam_word_t acam_d_i;

  logic                 ts_valid_o;
  logic                 ts_ready_i;
  logic [C_FINE_W-1:0]  ts_fine_o;
  logic                 ts_slope_o;
  logic [C_START_W-1:0] ts_start_nb_o;
  logic [C_CHAN_W-1:0]  ts_channel_o;

  modport master (
    output acam_csn_o, acam_rdn_o, acam_wrn_o, acam_adr_o,
    input  acam_d_i,
    output ts_valid_o, ts_fine_o, ts_slope_o, ts_start_nb_o, ts_channel_o,
    input  ts_ready_i
  );

  modport slave (
    input  acam_csn_o, acam_rdn_o, acam_wrn_o, acam_adr_o,
    output acam_d_i,
    input  ts_valid_o, ts_fine_o, ts_slope_o, ts_start_nb_o, ts_channel_o,
    output ts_ready_i
  );
endinterface

// File: rtl/acam_ef_sync.sv
// Multi-flop synchronizer for the asynchronous GPX empty flags; resets to "empty".
module acam_ef_sync #(
  parameter int unsigned G_SYNC_STAGES = 2,
  parameter int unsigned G_WIDTH       = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [G_WIDTH-1:0] ef_i,
  output logic [G_WIDTH-1:0] ef_o
);

  logic [G_SYNC_STAGES-1:0][G_WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[G_SYNC_STAGES-2:0], ef_i};
    end
  end

  assign ef_o = sync_q[G_SYNC_STAGES-1];

endmodule

// File: rtl/acam_fifo_readout_ctrl.sv
// Round-robin reader of GPX IFIFO0/IFIFO1 with a single-entry decoded timestamp slot.
// Optional statistics counters: define ACAM_READOUT_STATS_EN.
module acam_fifo_readout_ctrl
  import acam_readout_pkg::*;
#(
  parameter int unsigned G_RD_LOW_CYCLES = 3,
  parameter int unsigned G_EF_HOLDOFF    = 4,
  parameter int unsigned G_SYNC_STAGES   = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic enable_i,
  input  logic ef1_i,
  input  logic ef2_i,
  acam_fifo_readout_ctrl_if.master bus,
  output logic busy_o
`ifdef ACAM_READOUT_STATS_EN
  ,
  output logic [31:0] stat_rd_cnt_o,
  output logic [31:0] stat_stall_cnt_o
`endif
);

  localparam int unsigned C_RD_CNT_W = $clog2(G_RD_LOW_CYCLES + 1);
  localparam int unsigned C_HO_W     = $clog2(G_EF_HOLDOFF + 1);
  localparam logic [C_RD_CNT_W-1:0] C_RD_LAST = C_RD_CNT_W'(G_RD_LOW_CYCLES - 1);
  localparam logic [C_HO_W-1:0]     C_HO_LOAD = C_HO_W'(G_EF_HOLDOFF);

  state_t                      state_q;
  logic                        csn_q;
  logic                        rdn_q;
  logic [3:0]                  adr_q;
  logic                        fifo_id_q;
  logic                        rr_q;
  logic [C_RD_CNT_W-1:0]       rd_cnt_q;
  logic [1:0][C_HO_W-1:0]      holdoff_q;
  logic                        ts_valid_q;
  acam_ts_t                    ts_q;

  logic [1:0] ef_sync;
  logic [1:0] elig_c;
  logic       slot_free_c;
  logic       start_c;
  logic       pick_c;

  // ef_sync[0] tracks EF1 (IFIFO0), ef_sync[1] tracks EF2 (IFIFO1)
  acam_ef_sync #(
    .G_SYNC_STAGES (G_SYNC_STAGES),
    .G_WIDTH       (2)
  ) u_ef_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .ef_i    ({ef2_i, ef1_i}),
    .ef_o    (ef_sync)
  );

  // Eligibility, slot availability and round-robin choice
  always_comb begin
    elig_c = 2'b00;
    for (int k = 0; k < 2; k++) begin
      elig_c[k] = !ef_sync[k] && (holdoff_q[k] == '0) && enable_i;
    end
    slot_free_c = !ts_valid_q || bus.ts_ready_i;
    start_c     = (elig_c != 2'b00) && slot_free_c;
    pick_c      = (elig_c == 2'b11) ? rr_q : elig_c[1];
  end

  // Bus sequencer, output slot and holdoff counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      csn_q      <= 1'b1;
      rdn_q      <= 1'b1;
      adr_q      <= C_ADR_IFIFO0;
      fifo_id_q  <= 1'b0;
      rr_q       <= 1'b0;
      rd_cnt_q   <= '0;
      holdoff_q  <= '0;
      ts_valid_q <= 1'b0;
      ts_q       <= '0;
      busy_o     <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (holdoff_q[k] != '0) holdoff_q[k] <= holdoff_q[k] - C_HO_W'(1);
      end

      if (ts_valid_q && bus.ts_ready_i) ts_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_c) begin
            fifo_id_q <= pick_c;
            adr_q     <= pick_c ? C_ADR_IFIFO1 : C_ADR_IFIFO0;
            csn_q     <= 1'b0;
            busy_o    <= 1'b1;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          rdn_q    <= 1'b0;
          rd_cnt_q <= '0;
          state_q  <= RD_LOW;
        end
        RD_LOW: begin
          if (rd_cnt_q == C_RD_LAST) begin
            ts_q       <= decode_word(fifo_id_q, bus.acam_d_i);
            ts_valid_q <= 1'b1;
            rdn_q      <= 1'b1;
            state_q    <= RELEASE;
          end else begin
            rd_cnt_q <= rd_cnt_q + C_RD_CNT_W'(1);
          end
        end
        RELEASE: begin
          csn_q                <= 1'b1;
          holdoff_q[fifo_id_q] <= C_HO_LOAD;
          rr_q                 <= ~fifo_id_q;
          busy_o               <= 1'b0;
          state_q              <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.acam_csn_o    = csn_q;
  assign bus.acam_rdn_o    = rdn_q;
  assign bus.acam_wrn_o    = 1'b1;
  assign bus.acam_adr_o    = adr_q;
  assign bus.ts_valid_o    = ts_valid_q;
  assign bus.ts_fine_o     = ts_q.fine;
  assign bus.ts_slope_o    = ts_q.slope;
  assign bus.ts_start_nb_o = ts_q.start_nb;
  assign bus.ts_channel_o  = ts_q.channel;

`ifdef ACAM_READOUT_STATS_EN
  // Delivered-word and blocked-while-eligible counters, wrapping at 2^32
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_rd_cnt_o    <= '0;
      stat_stall_cnt_o <= '0;
    end else begin
      if (ts_valid_q && bus.ts_ready_i) stat_rd_cnt_o <= stat_rd_cnt_o + 32'd1;
      if ((elig_c != 2'b00) && ts_valid_q && !bus.ts_ready_i)
        stat_stall_cnt_o <= stat_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_acam_fifo_readout_ctrl.sv
// Bench for acam_fifo_readout_ctrl: queue-based GPX FIFO model on the bus, per-FIFO scoreboard.
module tb_acam_fifo_readout_ctrl;
  import acam_readout_pkg::*;

  localparam int RD_LOW  = 3;
  localparam int HOLDOFF = 4;
  localparam int SYNC    = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic ef1, ef2;
  logic busy;
`ifdef ACAM_READOUT_STATS_EN
  logic [31:0] stat_rd, stat_stall;
`endif

  acam_fifo_readout_ctrl_if bus ();

  acam_fifo_readout_ctrl #(
    .G_RD_LOW_CYCLES (RD_LOW),
    .G_EF_HOLDOFF    (HOLDOFF),
    .G_SYNC_STAGES   (SYNC)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .enable_i (enable),
    .ef1_i    (ef1),
    .ef2_i    (ef2),
    .bus      (bus),
    .busy_o   (busy)
`ifdef ACAM_READOUT_STATS_EN
    ,
    .stat_rd_cnt_o    (stat_rd),
    .stat_stall_cnt_o (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus requests (written by the initial block only)
  logic [27:0] req_word [0:1023];
  logic        req_fifo [0:1023];
  int          req_wr = 0;

  // GPX model and output monitor state (written by the model block only)
  logic [27:0] q0[$], q1[$];
  int          req_rd = 0;
  int          rd_empty_err = 0, rd_done = 0, rd_start = 0;
  logic        csn_p = 1'b1, rdn_p = 1'b1;
  logic [28:0] acc_log [0:1023];
  int          acc_cnt = 0;
  int          unstable = 0;
  logic [28:0] prev_word = '0;
  logic        prev_stall = 1'b0;
  int          hs_since_rst = 0;
  int          stall_bench = 0;
  int          cyc = 0;
  int          last_rel [2] = '{-100, -100};
  logic [1:0]  ef_p1 = 2'b11, ef_p2 = 2'b11;

  // Expected words per FIFO (initial block only)
  logic [28:0] exp0[$], exp1[$];
  int          chk_idx = 0;

  initial begin
    ef1 = 1'b1;
    ef2 = 1'b1;
    bus.acam_d_i = '0;
  end

  always @(negedge clk) begin
    logic [28:0] cur;
    logic        sel;
    cyc = cyc + 1;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      req_rd       = req_wr;
      ef1          = 1'b1;
      ef2          = 1'b1;
      bus.acam_d_i = '0;
      csn_p        = 1'b1;
      rdn_p        = 1'b1;
      prev_stall   = 1'b0;
      hs_since_rst = 0;
      stall_bench  = 0;
      ef_p1        = 2'b11;
      ef_p2        = 2'b11;
      last_rel     = '{-100, -100};
    end else begin
      cur = {bus.ts_channel_o, bus.ts_start_nb_o, bus.ts_slope_o, bus.ts_fine_o};
      if (prev_stall && (!bus.ts_valid_o || cur !== prev_word)) unstable = unstable + 1;
      if (bus.ts_valid_o && bus.ts_ready_i) begin
        acc_log[acc_cnt] = cur;
        acc_cnt      = acc_cnt + 1;
        hs_since_rst = hs_since_rst + 1;
      end
      prev_stall = bus.ts_valid_o && !bus.ts_ready_i;
      prev_word  = cur;

      sel = (bus.acam_adr_o == 4'h9);
      if (!bus.acam_csn_o && !bus.acam_rdn_o && rdn_p) begin
        rd_start = rd_start + 1;
        if (bus.acam_adr_o != 4'h8 && bus.acam_adr_o != 4'h9) rd_empty_err = rd_empty_err + 1;
        else if (sel ? (q1.size() == 0) : (q0.size() == 0)) rd_empty_err = rd_empty_err + 1;
      end
      if (bus.acam_rdn_o && !rdn_p && !bus.acam_csn_o) begin
        rd_done = rd_done + 1;
        if (sel && q1.size() > 0) void'(q1.pop_front());
        else if (!sel && q0.size() > 0) void'(q0.pop_front());
      end
      if (bus.acam_csn_o && !csn_p) last_rel[sel] = cyc;

`ifdef ACAM_READOUT_STATS_EN
      begin
        logic any_elig;
        any_elig = 1'b0;
        for (int k = 0; k < 2; k++)
          if (!ef_p2[k] && (cyc - last_rel[k] >= HOLDOFF) && enable) any_elig = 1'b1;
        if (any_elig && bus.ts_valid_o && !bus.ts_ready_i) stall_bench = stall_bench + 1;
      end
`endif

      while (req_rd != req_wr) begin
        if (req_fifo[req_rd]) q1.push_back(req_word[req_rd]);
        else q0.push_back(req_word[req_rd]);
        req_rd = req_rd + 1;
      end
      csn_p = bus.acam_csn_o;
      rdn_p = bus.acam_rdn_o;
      ef1   = (q0.size() == 0);
      ef2   = (q1.size() == 0);
      ef_p2 = ef_p1;
      ef_p1 = {ef2, ef1};
      bus.acam_d_i = '0;
      if (!bus.acam_csn_o) begin
        if (sel && q1.size() > 0) bus.acam_d_i = q1[0];
        else if (!sel && q0.size() > 0) bus.acam_d_i = q0[0];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp = n_cmp + 1;
    assert (obs === exp_v) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Stop on TStop[stop] (1..8): TStop1-4 -> IFIFO0, TStop5-8 -> IFIFO1
  task automatic push_stop(input int stop, input int slope);
    logic [27:0] w;
    logic        k;
    k = 1'((stop - 1) / 4);
    w = {2'((stop - 1) % 4), 8'($urandom), 1'(slope), 17'($urandom)};
    req_word[req_wr] = w;
    req_fifo[req_wr] = k;
    req_wr = req_wr + 1;
    if (k) exp1.push_back({k, w});
    else   exp0.push_back({k, w});
  endtask

  task automatic drain_check(input string tag, input int n, input int budget, input bit rnd);
    int t = 0;
    logic [28:0] w, e;
    while (acc_cnt < chk_idx + n && t < budget) begin
      if (rnd) bus.ts_ready_i = 1'($urandom_range(0, 1));
      tick(1);
      t = t + 1;
    end
    chk({tag, "_count"}, acc_cnt, chk_idx + n);
    for (int i = 0; i < n; i++) begin
      w = acc_log[chk_idx];
      chk_idx = chk_idx + 1;
      if (w[28]) begin
        chk({tag, "_exp1_avail"}, 32'(exp1.size() > 0), 1);
        e = (exp1.size() > 0) ? exp1.pop_front() : ~w;
      end else begin
        chk({tag, "_exp0_avail"}, 32'(exp0.size() > 0), 1);
        e = (exp0.size() > 0) ? exp0.pop_front() : ~w;
      end
      chk({tag, "_word"}, 32'(w), 32'(e));
    end
  endtask

  task automatic wait_rdn_low(input string tag);
    int t = 0;
    while (bus.acam_rdn_o !== 1'b0 && t < 300) begin
      tick(1);
      t = t + 1;
    end
    chk({tag, "_rdn_low_seen"}, 32'(bus.acam_rdn_o), 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    exp0.delete();
    exp1.delete();
    tick(2);
    chk_idx = acc_cnt;
  endtask

  initial begin
    int lat, cnt, s, base;
    logic lastk;
    logic [28:0] w;
    rst_n  = 1'b1;
    enable = 1'b0;
    bus.ts_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    tick(3);

    // Reset state
    chk("rst_csn", 32'(bus.acam_csn_o), 1);
    chk("rst_rdn", 32'(bus.acam_rdn_o), 1);
    chk("rst_wrn", 32'(bus.acam_wrn_o), 1);
    chk("rst_adr", 32'(bus.acam_adr_o), 8);
    chk("rst_valid", 32'(bus.ts_valid_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ts_data", 32'({bus.ts_channel_o, bus.ts_start_nb_o, bus.ts_slope_o, bus.ts_fine_o}), 0);
    rst_n = 1'b1;
    tick(2);

    // 1: single stop on TStop1, latency and read-cycle length
    enable = 1'b1;
    bus.ts_ready_i = 1'b1;
    tick(1);
    push_stop(1, 1);
    lat = 0;
    while (bus.acam_csn_o && lat < 20) begin
      tick(1);
      lat = lat + 1;
    end
    chk("t1_ef_to_csn", lat, SYNC + 1);
    chk("t1_busy", 32'(busy), 1);
    cnt = 1;
    while (cnt < 20) begin
      tick(1);
      if (bus.acam_csn_o) break;
      cnt = cnt + 1;
    end
    chk("t1_csn_low_cycles", cnt, RD_LOW + 2);
    drain_check("t1", 1, 50, 1'b0);
    chk("t1_ch", 32'(acc_log[chk_idx-1][28:26]), 0);
    chk("t1_slope", 32'(acc_log[chk_idx-1][17]), 1);
    tick(20);
    chk("t1_fifo_empty", 32'(ef1), 1);
    chk("t1_busy_idle", 32'(busy), 0);
    chk("t1_rd_empty_err", rd_empty_err, 0);

    // 2: simultaneous stops on TStop1 and TStop5, round-robin alternation
    lastk = acc_log[chk_idx-1][28];
    base  = chk_idx;
    push_stop(1, 1);
    push_stop(5, 0);
    drain_check("t2", 2, 100, 1'b0);
    chk("t2_first_ch", 32'(acc_log[base][28:26]), 32'({~lastk, 2'b00}));
    chk("t2_second_ch", 32'(acc_log[base+1][28:26]), 32'({lastk, 2'b00}));
    chk("t2_rd_empty_err", rd_empty_err, 0);

    // 3: ten stops on TStop2 while the consumer stalls for 200 cycles
    bus.ts_ready_i = 1'b0;
    s = rd_done;
    for (int i = 0; i < 10; i++) begin
      push_stop(2, int'($urandom_range(0, 1)));
      tick(1);
    end
    tick(190);
    chk("t3_reads_in_stall", rd_done - s, 1);
    chk("t3_valid_held", 32'(bus.ts_valid_o), 1);
    chk("t3_unstable", unstable, 0);
    bus.ts_ready_i = 1'b1;
    drain_check("t3", 10, 2000, 1'b0);
    chk("t3_unstable_end", unstable, 0);

    // 4: enable dropped while RDN is low
    for (int i = 0; i < 4; i++) push_stop(4, 1);
    wait_rdn_low("t4");
    enable = 1'b0;
    drain_check("t4a", 1, 100, 1'b0);
    tick(5);
    chk("t4_csn_idle", 32'(bus.acam_csn_o), 1);
    s = rd_start;
    tick(60);
    chk("t4_no_reads", rd_start - s, 0);
    chk("t4_busy", 32'(busy), 0);
    enable = 1'b1;
    drain_check("t4b", 3, 500, 1'b0);

    // 5: reset pulse in the middle of RD_LOW
    for (int i = 0; i < 3; i++) push_stop(6, 0);
    wait_rdn_low("t5");
    #2 rst_n = 1'b0;
    #1;
    chk("t5_csn_async", 32'(bus.acam_csn_o), 1);
    chk("t5_rdn_async", 32'(bus.acam_rdn_o), 1);
    chk("t5_valid_async", 32'(bus.ts_valid_o), 0);
    tick(2);
    rst_n = 1'b1;
    exp0.delete();
    exp1.delete();
    tick(2);
    chk_idx = acc_cnt;
    base = chk_idx;
    push_stop(1, 1);
    push_stop(5, 1);
    drain_check("t5", 2, 200, 1'b0);
    chk("t5_first_ch", 32'(acc_log[base][28:26]), 0);
    chk("t5_second_ch", 32'(acc_log[base+1][28:26]), 4);

    // 7: randomized stops with random backpressure
    for (int i = 0; i < 24; i++) begin
      push_stop(int'($urandom_range(1, 8)), int'($urandom_range(0, 1)));
      bus.ts_ready_i = 1'($urandom_range(0, 1));
      tick(int'($urandom_range(1, 6)));
    end
    drain_check("rnd", 24, 3000, 1'b1);
    bus.ts_ready_i = 1'b1;
    tick(20);
    chk("rnd_no_extra", acc_cnt, chk_idx);
    chk("rnd_unstable", unstable, 0);
    chk("rnd_rd_empty_err", rd_empty_err, 0);
    w = {exp0.size() == 0, exp1.size() == 0, 27'd0};
    chk("rnd_all_consumed", 32'(w[28:27]), 3);

`ifdef ACAM_READOUT_STATS_EN
    // 6: statistics counters with injected stalls
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      push_stop(int'($urandom_range(1, 8)), 1);
      bus.ts_ready_i = 1'($urandom_range(0, 1));
      tick(int'($urandom_range(1, 4)));
    end
    drain_check("stat", 7, 2000, 1'b1);
    bus.ts_ready_i = 1'b1;
    tick(20);
    chk("stat_rd_cnt", int'(stat_rd), 7);
    chk("stat_rd_vs_bench", int'(stat_rd), hs_since_rst);
    chk("stat_stall_cnt", int'(stat_stall), stall_bench);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
